// File: rtl/imc_seq_pkg.sv
// ---------------------------------------------------------------------------
// imc_seq_pkg : shared types and defaults for the IMC MAC sequencer.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package imc_seq_pkg;

  localparam int unsigned IMC_MEM_ROW  = 16;
  localparam int unsigned IMC_BUF_AW   = 4;
  localparam int unsigned IMC_PRE_CYC  = 2;
  localparam int unsigned IMC_EVAL_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PRECH = 3'd3,
    ST_EVAL  = 3'd4,
    ST_SENSE = 3'd5,
    ST_WRITE = 3'd6,
    ST_DONE  = 3'd7
  } seq_state_e;

  // Counter width able to hold the longest phase length minus one.
  function automatic int unsigned timer_width(int unsigned pre_cyc, int unsigned eval_cyc);
    int unsigned longest;
    longest = (pre_cyc > eval_cyc) ? pre_cyc : eval_cyc;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imc_phase_timer.sv
// ---------------------------------------------------------------------------
// imc_phase_timer : loadable down-counter with zero flag.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imc_phase_timer
  import imc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = timer_width(IMC_PRE_CYC, IMC_EVAL_CYC)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/imc_mac_sequencer.sv
// ---------------------------------------------------------------------------
// imc_mac_sequencer : walks IB[0..last], runs one IMC MAC per entry, writes OB.
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imc_mac_sequencer
  import imc_seq_pkg::*;
#(
  parameter int unsigned MEM_ROW  = IMC_MEM_ROW,
  parameter int unsigned BUF_AW   = IMC_BUF_AW,
  parameter int unsigned PRE_CYC  = IMC_PRE_CYC,
  parameter int unsigned EVAL_CYC = IMC_EVAL_CYC
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [BUF_AW-1:0]  last_addr,
  input  logic               empty_IB,
  input  logic [MEM_ROW-1:0] IB_data,
  output logic               IB_rd_en,
  output logic               OB_wr_en,
  output logic               SA_wr_en,
  output logic [BUF_AW-1:0]  BUF_addr,
  output logic [MEM_ROW-1:0] RWL,
  output logic [MEM_ROW-1:0] RWLB,
  output logic               PRE_A,
  output logic               PRE_CLSA,
  output logic               SAEN,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned TW = timer_width(PRE_CYC, EVAL_CYC);
  localparam logic [TW-1:0] PRE_LOAD  = TW'(PRE_CYC - 1);
  localparam logic [TW-1:0] EVAL_LOAD = TW'(EVAL_CYC - 1);

  seq_state_e         state_q, state_d;
  logic [BUF_AW-1:0]  addr_q,  addr_d;
  logic [BUF_AW-1:0]  last_q,  last_d;
  logic [MEM_ROW-1:0] vec_q,   vec_d;
  logic               err_q,   err_d;

  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_zero;

  imc_phase_timer #(
    .WIDTH (TW)
  ) u_phase_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    vec_d    = vec_q;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    IB_rd_en = 1'b0;
    OB_wr_en = 1'b0;
    SA_wr_en = 1'b0;
    RWL      = '0;
    RWLB     = '0;
    PRE_A    = 1'b0;
    PRE_CLSA = 1'b0;
    SAEN     = 1'b0;
    en       = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (empty_IB) begin
            err_d = 1'b1;
          end else begin
            last_d  = last_addr;
            addr_d  = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        IB_rd_en = 1'b1;
        state_d  = ST_LOAD;
      end
      ST_LOAD: begin
        vec_d    = IB_data;
        tmr_load = 1'b1;
        tmr_val  = PRE_LOAD;
        state_d  = ST_PRECH;
      end
      ST_PRECH: begin
        PRE_A    = 1'b1;
        PRE_CLSA = 1'b1;
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = EVAL_LOAD;
          state_d  = ST_EVAL;
        end
      end
      ST_EVAL: begin
        RWL  = vec_q;
        RWLB = ~vec_q;
        en   = 1'b1;
        if (tmr_zero) begin
          state_d = ST_SENSE;
        end
      end
      ST_SENSE: begin
        RWL     = vec_q;
        RWLB    = ~vec_q;
        en      = 1'b1;
        SAEN    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // The write strobe is dropped if abort lands on this very cycle.
        OB_wr_en = !abort;
        SA_wr_en = !abort;
        if (addr_q == last_q) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + BUF_AW'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        done    = !abort;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      addr_d   = '0;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      vec_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
    end
  end

  assign BUF_addr = addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imc_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_imc_mac_sequencer : timeline-model bench for imc_mac_sequencer.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imc_mac_sequencer;

  typedef struct packed {
    logic        ib_rd;
    logic        ob_wr;
    logic        sa_wr;
    logic [3:0]  addr;
    logic [15:0] rwl;
    logic [15:0] rwlb;
    logic        pre_a;
    logic        pre_clsa;
    logic        saen;
    logic        en;
    logic        busy;
    logic        done;
    logic        err;
  } outs_t;

  logic        clk;
  logic        reset_n;
  logic        start, start2, abort, empty_IB;
  logic [3:0]  last_addr;
  logic [15:0] IB_data1, IB_data2;

  logic        ib_rd1, ob_wr1, sa_wr1, pre_a1, pre_clsa1, saen1, en1, busy1, done1, err1;
  logic [3:0]  addr1;
  logic [15:0] rwl1, rwlb1;
  logic        ib_rd2, ob_wr2, sa_wr2, pre_a2, pre_clsa2, saen2, en2, busy2, done2, err2;
  logic [3:0]  addr2;
  logic [15:0] rwl2, rwlb2;

  logic [15:0] mem1 [16];
  logic [15:0] mem2 [16];

  int checks = 0;
  int errors = 0;

  imc_mac_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .last_addr(last_addr), .empty_IB(empty_IB), .IB_data(IB_data1),
    .IB_rd_en(ib_rd1), .OB_wr_en(ob_wr1), .SA_wr_en(sa_wr1), .BUF_addr(addr1),
    .RWL(rwl1), .RWLB(rwlb1), .PRE_A(pre_a1), .PRE_CLSA(pre_clsa1),
    .SAEN(saen1), .en(en1), .busy(busy1), .done(done1), .err(err1)
  );

  imc_mac_sequencer #(.PRE_CYC(1), .EVAL_CYC(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .abort(abort),
    .last_addr(last_addr), .empty_IB(empty_IB), .IB_data(IB_data2),
    .IB_rd_en(ib_rd2), .OB_wr_en(ob_wr2), .SA_wr_en(sa_wr2), .BUF_addr(addr2),
    .RWL(rwl2), .RWLB(rwlb2), .PRE_A(pre_a2), .PRE_CLSA(pre_clsa2),
    .SAEN(saen2), .en(en2), .busy(busy2), .done(done2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input buffers: read data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (ib_rd1) IB_data1 <= mem1[addr1];
    if (ib_rd2) IB_data2 <= mem2[addr2];
  end

  function automatic outs_t observe(bit d2);
    if (d2)
      return outs_t'({ib_rd2, ob_wr2, sa_wr2, addr2, rwl2, rwlb2, pre_a2, pre_clsa2,
                      saen2, en2, busy2, done2, err2});
    return outs_t'({ib_rd1, ob_wr1, sa_wr1, addr1, rwl1, rwlb1, pre_a1, pre_clsa1,
                    saen1, en1, busy1, done1, err1});
  endfunction

  // Expected outputs in cycle k of a run (k=0 is the start cycle), built from
  // the per-vector timeline: fetch, load, P precharge, E evaluate, sense, write.
  function automatic outs_t model(bit d2, int k, int L, int a);
    outs_t e;
    int P, E, V, total, i, o;
    logic [15:0] w;
    e = '0;
    P = d2 ? 1 : 2;
    E = d2 ? 3 : 2;
    V = 4 + P + E;
    total = (L + 1) * V + 1;
    if (a >= 0 && k > a) return e;
    if (k > total) begin
      e.addr = L[3:0];
      return e;
    end
    if (k == total) begin
      e.busy = 1'b1;
      e.addr = L[3:0];
      e.done = (k != a);
      return e;
    end
    i = (k - 1) / V;
    o = (k - 1) % V;
    w = d2 ? mem2[i] : mem1[i];
    e.busy     = 1'b1;
    e.addr     = i[3:0];
    e.ib_rd    = (o == 0);
    e.pre_a    = (o >= 2) && (o < 2 + P);
    e.pre_clsa = e.pre_a;
    e.en       = (o >= 2 + P) && (o <= 2 + P + E);
    e.saen     = (o == 2 + P + E);
    e.rwl      = e.en ? w : 16'h0000;
    e.rwlb     = e.en ? ~w : 16'h0000;
    e.ob_wr    = (o == 3 + P + E) && (k != a);
    e.sa_wr    = e.ob_wr;
    return e;
  endfunction

  task automatic run_scn(input string tag, input bit d2, input int L, input int a,
                         input int poke_k, output int nwr, output int done_k);
    int P, E, total, last_k;
    outs_t e, o;
    P = d2 ? 1 : 2;
    E = d2 ? 3 : 2;
    total = (L + 1) * (4 + P + E) + 1;
    last_k = (a >= 0) ? a + 3 : total + 2;
    nwr = 0;
    done_k = -1;
    @(posedge clk); #1;
    last_addr = L[3:0];
    empty_IB = 1'b0;
    abort = 1'b0;
    if (d2) start2 = 1'b1; else start = 1'b1;
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      start2 = 1'b0;
      abort = (k == a);
      if (k == poke_k) begin
        if (d2) start2 = 1'b1; else start = 1'b1;
        last_addr = ~L[3:0];
      end
      #1;
      e = model(d2, k, L, a);
      o = observe(d2);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, k, o, e);
      end
      if (o.ob_wr === 1'b1) nwr++;
      if (o.done === 1'b1 && done_k < 0) done_k = k;
    end
    start = 1'b0;
    start2 = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (observe(1'b0) !== '0 || observe(1'b1) !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h / %h expected 0", observe(1'b0), observe(1'b1));
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (observe(1'b0) !== '0 || observe(1'b1) !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h / %h expected 0", observe(1'b0), observe(1'b1));
    end
  endtask

  task automatic test_single;
    int nwr, dk;
    mem1[0] = 16'hA5C3;
    run_scn("single", 1'b0, 0, -1, -1, nwr, dk);
    checks++;
    if (nwr != 1 || dk != 9) begin
      errors++;
      $display("FAIL single_summary: writes %0d done@%0d expected 1 / 9", nwr, dk);
    end
  endtask

  task automatic test_full_run;
    int nwr, dk;
    for (int i = 0; i < 16; i++) mem1[i] = 16'($urandom);
    run_scn("full", 1'b0, 15, -1, -1, nwr, dk);
    checks++;
    if (nwr != 16 || dk != 129) begin
      errors++;
      $display("FAIL full_summary: writes %0d done@%0d expected 16 / 129", nwr, dk);
    end
  endtask

  task automatic test_empty_ib;
    int nerr, nbusy, nrd;
    nerr = 0; nbusy = 0; nrd = 0;
    @(posedge clk); #1;
    empty_IB = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      if (err1 === 1'b1) nerr++;
      if (busy1 !== 1'b0) nbusy++;
      if (ib_rd1 !== 1'b0) nrd++;
    end
    empty_IB = 1'b0;
    checks++;
    if (nerr != 1 || nbusy != 0 || nrd != 0) begin
      errors++;
      $display("FAIL empty_ib: err_cycles %0d busy_cycles %0d rd_cycles %0d expected 1/0/0",
               nerr, nbusy, nrd);
    end
  endtask

  task automatic test_abort;
    int nwr, dk;
    for (int i = 0; i < 16; i++) mem1[i] = 16'($urandom);
    run_scn("abort", 1'b0, 5, 1 + 3 * 8 + 4, -1, nwr, dk);
    checks++;
    if (nwr != 3 || dk != -1) begin
      errors++;
      $display("FAIL abort_summary: writes %0d done@%0d expected 3 / -1", nwr, dk);
    end
  endtask

  task automatic test_busy_start;
    int nwr, dk;
    for (int i = 0; i < 16; i++) mem1[i] = 16'($urandom);
    run_scn("busy_start", 1'b0, 3, -1, 5, nwr, dk);
    checks++;
    if (nwr != 4 || dk != 33) begin
      errors++;
      $display("FAIL busy_start_summary: writes %0d done@%0d expected 4 / 33", nwr, dk);
    end
  endtask

  task automatic test_abort_start_idle;
    int nbad;
    nbad = 0;
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    last_addr = 4'd2;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      #1;
      if (busy1 !== 1'b0 || ib_rd1 !== 1'b0 || err1 !== 1'b0) nbad++;
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL abort_start_idle: active cycles %0d expected 0", nbad);
    end
  endtask

  task automatic test_phase_widths;
    int nwr, dk;
    for (int i = 0; i < 16; i++) mem2[i] = 16'($urandom);
    run_scn("phase13", 1'b1, 2, -1, -1, nwr, dk);
    checks++;
    if (nwr != 3 || dk != 25) begin
      errors++;
      $display("FAIL phase13_summary: writes %0d done@%0d expected 3 / 25", nwr, dk);
    end
  endtask

  task automatic test_async_reset;
    int nwr, dk;
    mem1[0] = 16'($urandom);
    @(posedge clk); #1;
    last_addr = 4'd0;
    start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (saen1 !== 1'b1 || en1 !== 1'b1) begin
      errors++;
      $display("FAIL sense_entry: saen %b en %b expected 1 1", saen1, en1);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (observe(1'b0) !== '0) begin
      errors++;
      $display("FAIL async_clear: got %h expected 0", observe(1'b0));
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observe(1'b0) !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0", observe(1'b0));
    end
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 16; i++) mem1[i] = 16'($urandom);
    run_scn("post_reset", 1'b0, 1, -1, -1, nwr, dk);
    checks++;
    if (nwr != 2 || dk != 17) begin
      errors++;
      $display("FAIL post_reset_summary: writes %0d done@%0d expected 2 / 17", nwr, dk);
    end
  endtask

  task automatic test_random;
    int nwr, dk, L, a, total;
    bit d2;
    for (int it = 0; it < 5; it++) begin
      d2 = 1'($urandom_range(0, 1));
      L = int'($urandom_range(0, 15));
      total = (L + 1) * 8 + 1;
      a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, total)) : -1;
      for (int i = 0; i < 16; i++) begin
        mem1[i] = 16'($urandom);
        mem2[i] = 16'($urandom);
      end
      run_scn("random", d2, L, a, -1, nwr, dk);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    abort = 1'b0;
    empty_IB = 1'b0;
    last_addr = 4'd0;
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 16'h0000;
      mem2[i] = 16'h0000;
    end
    test_reset();
    test_single();
    test_full_run();
    test_empty_ib();
    test_abort();
    test_busy_start();
    test_abort_start_idle();
    test_phase_widths();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/imc_mac_sequencer.md
# imc_mac_sequencer

Cycle-level sequencer for in-memory MAC operations on the 16-row SRAM IMC macro. On a start command it walks the input buffer from address 0 to a programmed last address. For each entry it reads one 16-bit input vector, precharges the sense path, drives the read word lines, fires the sense amplifier and writes the ADC result into the output buffer at the same address. It sits between the instruction-decode controller, which issues start, and the buffers/macro, taking over the MAC phase signals.

## Interface

Parameters:

- MEM_ROW, 16, number of word lines; also the input vector width
- BUF_AW, 4, buffer address width
- PRE_CYC, 2, precharge phase length in cycles (≥1)
- EVAL_CYC, 2, word-line evaluate phase length in cycles (≥1)

Ports:

- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE next cycle
- last_addr  in  BUF_AW  final buffer address; sampled at start
- empty_IB  in  1  input buffer empty flag
- IB_data  in  MEM_ROW  input buffer read data, valid 1 cycle after IB_rd_en
- IB_rd_en  out  1  input buffer read strobe
- OB_wr_en  out  1  output buffer write strobe; OB captures IMC_out externally
- SA_wr_en  out  1  SA buffer write strobe, coincident with OB_wr_en
- BUF_addr  out  BUF_AW  shared buffer address for IB read, OB write and SA write
- RWL  out  MEM_ROW  read word lines
- RWLB  out  MEM_ROW  complementary read word lines
- PRE_A, PRE_CLSA  out  1 each  precharge, active-high
- SAEN  out  1  sense-amplifier enable
- en  out  1  EN/VCLP enable, high during evaluate and sense
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse when start is rejected because of empty_IB

## Operation

- States: IDLE, FETCH, LOAD, PRECH, EVAL, SENSE, WRITE, DONE.
- IDLE:
  - start=1 and empty_IB=0: latch last_addr, set BUF_addr=0, go to FETCH.
  - start=1 and empty_IB=1: pulse err, stay in IDLE.
- FETCH: IB_rd_en=1 for one cycle.
- LOAD: register IB_data into vec_q.
- PRECH: PRE_A=PRE_CLSA=1 for PRE_CYC cycles.
- EVAL: RWL=vec_q, RWLB=~vec_q, en=1 for EVAL_CYC cycles.
- SENSE: RWL/RWLB held, en=1, SAEN=1 for one cycle.
- WRITE: OB_wr_en=SA_wr_en=1 at the current BUF_addr; RWL/RWLB return to 0.
  - BUF_addr==last_q: go to DONE.
  - Otherwise: BUF_addr+1, go to FETCH.
- DONE: done=1 for one cycle, then IDLE. BUF_addr holds last value until the next start.
- Outside the states listed above, RWL, RWLB, PRE_A, PRE_CLSA, SAEN and en are 0.
- Phase lengths come from one down-counter loaded on state entry.
- Reset value of every output is 0; the state after reset is IDLE.

## Timing

- Per-vector latency: 4+PRE_CYC+EVAL_CYC cycles (8 at defaults).
- Total run length: (last_addr+1)·(4+PRE_CYC+EVAL_CYC)+1 cycles from the start edge to the done pulse.
- Boundary and conflict rules:
  - start while busy: ignored.
  - last_addr changing mid-run: no effect, since it was latched at start.
  - last_addr=0: exactly one vector is processed.
  - last_addr=2^BUF_AW−1: all entries are processed, with no wrap.
  - abort in any non-IDLE state: next cycle is IDLE with all outputs 0, no done, and no OB write for the in-flight vector.
  - abort and start in the same cycle in IDLE: abort wins, start is dropped.
  - reset_n low mid-run: outputs clear immediately (asynchronous); no partial write survives.
- RWL/RWLB never change in the same cycle that SAEN is high.

## Structure

- Package imc_seq_pkg holds:
  - the state enumeration
  - default PRE_CYC/EVAL_CYC constants
  - MEM_ROW/BUF_AW defaults shared with the controller
- Sub-module imc_phase_timer: a loadable down-counter with a zero flag, used for the PRECH and EVAL durations.

## Test plan

- Reset then idle: all outputs 0, busy=0 → start, last_addr=0, IB[0]=16'hA5C3. Required: RWL=16'hA5C3 and RWLB=16'h5A3C during EVAL; OB write at addr 0; done 9 cycles after start.
- Full run, last_addr=15: BUF_addr steps 0..15; exactly 16 OB_wr_en pulses; done at cycle 129; no wrap to 0.
- start with empty_IB=1: err pulses for 1 cycle, busy stays 0, no IB_rd_en.
- abort during EVAL of vector 3: next cycle IDLE with RWL=0; OB writes only at addresses 0–2; done never pulses.
- start asserted at cycle 5 of a run: ignored; last_addr change mid-run has no effect. Also with PRE_CYC=1, EVAL_CYC=3: each vector takes 8 cycles with the phase widths matching.
- reset_n dropped during SENSE: SAEN and en fall asynchronously. After release, a fresh start runs correctly from addr 0.
